// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: two requesters share one UART transmitter. Grants are held for a
// whole frame (until a byte flagged "last" completes), frames alternate round-robin
// under contention, and a stalled frame is aborted after TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int          D_BIT   = 7,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0,
  input  logic           req1,
  input  logic [D_BIT:0] dato0,
  input  logic [D_BIT:0] dato1,
  input  logic           last0,
  input  logic           last1,
  output logic           ack0,
  output logic           ack1,
  input  logic           tx_done,
  output logic           tx_start,
  output logic [D_BIT:0] tx_dato_in,
  output logic [1:0]     gnt,
  output logic           busy,
  output logic           err
);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, HOLD} state_e;

  // Last counter value that still counts as "in time"; reaching it without an exit aborts.
  localparam logic [15:0] TIMEOUT_LAST = TIMEOUT - 16'd1;

  state_e         state_q, state_d;
  logic [1:0]     gnt_q, gnt_d;
  logic           last_served_q, last_served_d;
  logic           last_q, last_d;
  logic [D_BIT:0] tx_dato_q, tx_dato_d;
  logic           tx_start_q, tx_start_d;
  logic [1:0]     ack_q, ack_d;
  logic           err_q, err_d;
  logic [15:0]    cnt_q, cnt_d;

  logic           grant_req;
  logic           grant_last;
  logic [D_BIT:0] grant_dato;
  logic           expired;
  logic           abort;

  // Once a grant is locked, only the granted requester's signals matter.
  always_comb begin
    grant_req  = gnt_q[1] ? req1  : req0;
    grant_last = gnt_q[1] ? last1 : last0;
    grant_dato = gnt_q[1] ? dato1 : dato0;
    expired    = (cnt_q == TIMEOUT_LAST);
  end

  // Next-state and registered-output decisions for the frame FSM.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_served_d = last_served_q;
    last_d        = last_q;
    tx_dato_d     = tx_dato_q;
    tx_start_d    = 1'b0;
    ack_d         = 2'b00;
    err_d         = 1'b0;
    abort         = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Requester 0 wins a tie only when requester 1 was served last.
          if (req0 && (!req1 || last_served_q)) begin
            gnt_d = 2'b01;
          end else begin
            gnt_d = 2'b10;
          end
          ack_d   = gnt_d;
          state_d = LOAD;
        end
      end
      LOAD: begin
        tx_dato_d  = grant_dato;
        last_d     = grant_last;
        tx_start_d = 1'b1;
        state_d    = START;
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        // A byte completing on the expiry cycle still counts as completed.
        if (tx_done) begin
          if (last_q) begin
            last_served_d = gnt_q[1];
            gnt_d         = 2'b00;
            state_d       = IDLE;
          end else if (grant_req) begin
            ack_d   = gnt_q;
            state_d = LOAD;
          end else begin
            state_d = HOLD;
          end
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      HOLD: begin
        if (grant_req) begin
          ack_d   = gnt_q;
          state_d = LOAD;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      default: begin
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      err_d         = 1'b1;
      gnt_d         = 2'b00;
      last_served_d = gnt_q[1];
      state_d       = IDLE;
    end
  end

  // The timeout counter runs across WAIT and HOLD of one byte and restarts otherwise.
  always_comb begin
    cnt_d = 16'd0;
    if ((state_q == WAIT || state_q == HOLD) && (state_d == WAIT || state_d == HOLD)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      gnt_q         <= 2'b00;
      last_served_q <= 1'b1;
      last_q        <= 1'b0;
      tx_dato_q     <= '0;
      tx_start_q    <= 1'b0;
      ack_q         <= 2'b00;
      err_q         <= 1'b0;
      cnt_q         <= 16'd0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      last_served_q <= last_served_d;
      last_q        <= last_d;
      tx_dato_q     <= tx_dato_d;
      tx_start_q    <= tx_start_d;
      ack_q         <= ack_d;
      err_q         <= err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign ack0       = ack_q[0];
  assign ack1       = ack_q[1];
  assign tx_start   = tx_start_q;
  assign tx_dato_in = tx_dato_q;
  assign gnt        = gnt_q;
  assign busy       = (state_q != IDLE);
  assign err        = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vectors and multi-cycle sequences for uart_tx_arbiter.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int          D_BIT   = 7;
  localparam logic [15:0] TIMEOUT = 16'd100;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       req0    = 1'b0;
  logic       req1    = 1'b0;
  logic [7:0] dato0   = 8'h00;
  logic [7:0] dato1   = 8'h00;
  logic       last0   = 1'b0;
  logic       last1   = 1'b0;
  logic       tx_done = 1'b0;
  logic       ack0, ack1, tx_start, busy, err;
  logic [7:0] tx_dato_in;
  logic [1:0] gnt;

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    logic       req0;
    logic [7:0] dato0;
    logic       last0;
    logic       req1;
    logic [7:0] dato1;
    logic       last1;
    logic       txDone;
    logic       ack0;
    logic       ack1;
    logic       txStart;
    logic [7:0] txDato;
    logic [1:0] gnt;
    logic       busy;
    logic       err;
  } vecT;

  vecT vecs [17];

  uart_tx_arbiter #(
    .D_BIT  (D_BIT),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .dato0     (dato0),
    .dato1     (dato1),
    .last0     (last0),
    .last1     (last1),
    .ack0      (ack0),
    .ack1      (ack1),
    .tx_done   (tx_done),
    .tx_start  (tx_start),
    .tx_dato_in(tx_dato_in),
    .gnt       (gnt),
    .busy      (busy),
    .err       (err)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Advance one cycle; outputs are then sampled 1 ns after the edge and tx_done self-clears.
  task automatic step();
    @(posedge clk);
    #1;
    tx_done = 1'b0;
  endtask

  task automatic applyStimulus(input vecT v);
    req0    = v.req0;
    dato0   = v.dato0;
    last0   = v.last0;
    req1    = v.req1;
    dato1   = v.dato1;
    last1   = v.last1;
    tx_done = v.txDone;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput($sformatf("%s.gnt", tag), gnt, 0);
    checkOutput($sformatf("%s.busy", tag), busy, 0);
    checkOutput($sformatf("%s.ack", tag), {ack1, ack0}, 0);
    checkOutput($sformatf("%s.txStart", tag), tx_start, 0);
    checkOutput($sformatf("%s.err", tag), err, 0);
    checkOutput($sformatf("%s.txDato", tag), tx_dato_in, 0);
  endtask

  task automatic waitAck(input int port, input string tag, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(ack0 || ack1) && n < 30);
    checkOutput($sformatf("%s.ackPort", tag), {30'd0, ack1, ack0}, (port == 0) ? 32'd1 : 32'd2);
  endtask

  // One byte: wait for its ack, check the start pulse and byte, stage the next byte,
  // stay quiet for gapCycles after tx_start, then raise tx_done for one cycle.
  task automatic runByte(input int port, input logic [7:0] expByte, input logic [7:0] nextByte,
                         input logic nextLast, input logic nextReq, input int expWait,
                         input int gapCycles, input string tag);
    int n;
    int stray;
    logic [1:0] expGnt;
    expGnt = (port == 0) ? 2'b01 : 2'b10;
    waitAck(port, tag, n);
    checkOutput($sformatf("%s.ackLatency", tag), n, expWait);
    step();
    checkOutput($sformatf("%s.txStart", tag), tx_start, 1);
    checkOutput($sformatf("%s.txDato", tag), tx_dato_in, expByte);
    checkOutput($sformatf("%s.gnt", tag), gnt, expGnt);
    if (port == 0) begin
      req0 = nextReq; dato0 = nextByte; last0 = nextLast;
    end else begin
      req1 = nextReq; dato1 = nextByte; last1 = nextLast;
    end
    stray = 0;
    repeat (gapCycles) begin
      step();
      if (ack0 || ack1 || tx_start || err || gnt != expGnt || tx_dato_in != expByte) stray++;
    end
    checkOutput($sformatf("%s.quiet", tag), stray, 0);
    tx_done = 1'b1;
  endtask

  initial begin
    int n;
    int bad;

    // Reset values while rst_n is low.
    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst_n = 1'b1;

    // Table: inputs applied during the row's cycle, expected outputs seen in that cycle.
    //          req0 dato0  l0    req1 dato1  l1    done  ack0 ack1 start txDato gnt    busy err
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2'b10, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 2'b10, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 2'b10, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A, 2'b00, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h11, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 2'b00, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 8'h11, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A, 2'b01, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 8'h12, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 2'b01, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 8'h12, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 2'b01, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 8'h12, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11, 2'b01, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 2'b01, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h12, 2'b01, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h12, 2'b00, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h12, 2'b10, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 2'b10, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 2'b10, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 2'b00, 1'b0, 1'b0};

    for (int i = 0; i < 17; i++) begin
      step();
      checkOutput($sformatf("row%0d.ack0", i), ack0, vecs[i].ack0);
      checkOutput($sformatf("row%0d.ack1", i), ack1, vecs[i].ack1);
      checkOutput($sformatf("row%0d.txStart", i), tx_start, vecs[i].txStart);
      checkOutput($sformatf("row%0d.txDato", i), tx_dato_in, vecs[i].txDato);
      checkOutput($sformatf("row%0d.gnt", i), gnt, vecs[i].gnt);
      checkOutput($sformatf("row%0d.busy", i), busy, vecs[i].busy);
      checkOutput($sformatf("row%0d.err", i), err, vecs[i].err);
      applyStimulus(vecs[i]);
    end

    // Three-byte frame from requester 0, tx_done 10 cycles after each tx_start.
    req0 = 1'b1; dato0 = 8'h41; last0 = 1'b0;
    runByte(0, 8'h41, 8'h42, 1'b0, 1'b1, 1, 10, "frame.b0");
    runByte(0, 8'h42, 8'h43, 1'b1, 1'b1, 1, 10, "frame.b1");
    runByte(0, 8'h43, 8'h00, 1'b0, 1'b0, 1, 10, "frame.b2");
    step();
    checkOutput("frame.endBusy", busy, 0);
    checkOutput("frame.endGnt", gnt, 0);

    // Contention from reset: requester 0's frame, then requester 1's, then requester 0 again.
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    req0 = 1'b1; dato0 = 8'hA0; last0 = 1'b0;
    req1 = 1'b1; dato1 = 8'hB0; last1 = 1'b0;
    runByte(0, 8'hA0, 8'hA1, 1'b1, 1'b1, 1, 3, "cont.r0b0");
    runByte(0, 8'hA1, 8'hC0, 1'b1, 1'b1, 1, 3, "cont.r0b1");
    runByte(1, 8'hB0, 8'hB1, 1'b1, 1'b1, 2, 3, "cont.r1b0");
    runByte(1, 8'hB1, 8'h00, 1'b0, 1'b0, 1, 3, "cont.r1b1");
    runByte(0, 8'hC0, 8'h00, 1'b0, 1'b0, 2, 3, "cont.r0c0");

    // Gap inside requester 1's frame while requester 0 waits.
    req1 = 1'b1; dato1 = 8'hD0; last1 = 1'b0;
    req0 = 1'b1; dato0 = 8'hE0; last0 = 1'b1;
    runByte(1, 8'hD0, 8'hD1, 1'b1, 1'b0, 2, 3, "gap.b0");
    bad = 0;
    repeat (20) begin
      step();
      if (gnt != 2'b10 || ack0 || ack1 || !busy || tx_start || err) bad++;
    end
    checkOutput("gap.hold", bad, 0);
    req1 = 1'b1;
    runByte(1, 8'hD1, 8'h00, 1'b0, 1'b0, 1, 3, "gap.b1");
    runByte(0, 8'hE0, 8'h00, 1'b0, 1'b0, 2, 3, "gap.r0");

    // Timeout: tx_done never arrives; a pending requester 1 is served afterwards.
    req0 = 1'b1; dato0 = 8'hF0; last0 = 1'b1;
    waitAck(0, "tmo", n);
    step();
    checkOutput("tmo.txStart", tx_start, 1);
    req0 = 1'b0;
    req1 = 1'b1; dato1 = 8'h77; last1 = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!err && n < 150);
    checkOutput("tmo.errCycle", n, 101);
    checkOutput("tmo.errGnt", gnt, 0);
    checkOutput("tmo.errBusy", busy, 0);
    step();
    checkOutput("tmo.errPulse", err, 0);
    checkOutput("tmo.ack1", ack1, 1);
    checkOutput("tmo.gnt", gnt, 2);

    // tx_done on the expiry cycle wins over the timeout.
    step();
    checkOutput("bnd.txStart", tx_start, 1);
    checkOutput("bnd.txDato", tx_dato_in, 8'h77);
    req1 = 1'b0;
    bad = 0;
    repeat (100) begin
      step();
      if (err || !busy) bad++;
    end
    checkOutput("bnd.noEarlyErr", bad, 0);
    tx_done = 1'b1;
    step();
    checkOutput("bnd.err", err, 0);
    checkOutput("bnd.busy", busy, 0);
    checkOutput("bnd.gnt", gnt, 0);
    tx_done = 1'b1;
    step();
    checkOutput("bnd.idleDoneErr", err, 0);
    checkOutput("bnd.idleDoneBusy", busy, 0);
    checkOutput("bnd.idleDoneStart", tx_start, 0);

    // Reset pulsed during WAIT, then a fresh request.
    req0 = 1'b1; dato0 = 8'h99; last0 = 1'b0;
    waitAck(0, "rst", n);
    step();
    checkOutput("rst.txStart", tx_start, 1);
    step();
    checkOutput("rst.waitBusy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    checkResetValues("rst.async");
    dato0 = 8'h31; last0 = 1'b1;
    bad = 0;
    repeat (3) begin
      step();
      if (tx_start || ack0 || ack1 || busy) bad++;
    end
    checkOutput("rst.held", bad, 0);
    rst_n = 1'b1;
    step();
    checkOutput("rst.ackN1", ack0, 1);
    step();
    checkOutput("rst.startN2", tx_start, 1);
    checkOutput("rst.datoN2", tx_dato_in, 8'h31);
    req0 = 1'b0;
    repeat (3) step();
    tx_done = 1'b1;
    step();
    checkOutput("rst.endBusy", busy, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
